// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch PC owner, single-outstanding imem reader and DEPTH-entry {pc,inst} FIFO
// Optional IFQ_BYPASS_EN: forwards a response straight to the output when the FIFO is empty.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [31:0]              inst_out,
  output logic [31:0]              pc_out,
  output logic [$clog2(DEPTH):0]   q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;
  state_t        r_state, w_next;
  logic [31:0]   r_fetch_pc, r_req_pc;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_inst_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_head_valid, w_issue, w_resp, w_bypass, w_push, w_pop;
  assign w_head_valid = r_count != '0;
  // Only one request in flight, so an empty slot in IDLE is the whole credit check.
  assign w_issue   = rst && r_state == IDLE && !redirect && r_count < FULL;
  assign w_resp    = r_state == WAIT && imem_rvalid && !redirect;
  assign imem_req  = w_issue;
  assign imem_addr = w_issue ? r_fetch_pc : '0;
  assign q_count   = r_count;
`ifdef IFQ_BYPASS_EN
  assign w_bypass   = w_resp && !w_head_valid;
  assign inst_valid = w_head_valid || w_bypass;
  assign inst_out   = w_head_valid ? r_inst_mem[r_rptr] : w_bypass ? imem_rdata : '0;
  assign pc_out     = w_head_valid ? r_pc_mem[r_rptr] : w_bypass ? r_req_pc : '0;
`else
  assign w_bypass   = 1'b0;
  assign inst_valid = w_head_valid;
  assign inst_out   = w_head_valid ? r_inst_mem[r_rptr] : '0;
  assign pc_out     = w_head_valid ? r_pc_mem[r_rptr] : '0;
`endif
  assign w_push = w_resp && !(w_bypass && inst_ready);
  assign w_pop  = w_head_valid && inst_ready && !redirect;
  // Next state: a redirect while waiting turns the outstanding response into one to drop.
  always_comb begin
    w_next = r_state == IDLE ? (w_issue ? WAIT : IDLE)
           : r_state == WAIT ? (imem_rvalid ? IDLE : redirect ? WAIT_DROP : WAIT)
           : (imem_rvalid ? IDLE : WAIT_DROP);
  end
  // State, fetch PC and FIFO bookkeeping; redirect clears the queue and restarts fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
    end else begin
      r_state <= w_next;
      if (redirect) r_fetch_pc <= {redirect_pc[31:2], 2'b00};
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_issue) r_req_pc <= r_fetch_pc;
      if (redirect) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) r_rptr <= r_rptr + 1'b1;
        r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
    end
  end
  // FIFO storage; contents are only observed through a valid head so they need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= r_req_pc;
      r_inst_mem[r_wptr] <= imem_rdata;
    end
  end
endmodule
